// File: rtl/inst_loader.sv
// inst_loader: receives a length-prefixed serial program image and writes
// it word by word into instruction memory, then releases the core reset.
module inst_loader #(
    parameter int CPU_WIDTH = 32,
    parameter int IMEM_AW   = 8,
    parameter int TIMEOUT   = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 byte_vld,
    input  logic [7:0]           byte_data,
    output logic                 byte_rdy,
    output logic                 imem_we,
    output logic [IMEM_AW-1:0]   imem_waddr,
    output logic [CPU_WIDTH-1:0] imem_wdata,
    output logic                 core_rst_n,
    output logic                 load_done,
    output logic                 load_err,
    output logic [1:0]           err_code
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [16:0] MAX_WORDS = 17'd1 << IMEM_AW;

    localparam logic [1:0] E_NONE = 2'd0;
    localparam logic [1:0] E_LEN  = 2'd1;
    localparam logic [1:0] E_CSUM = 2'd2;
    localparam logic [1:0] E_TOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [IMEM_AW-1:0]   widx_q, widx_d;
    logic [1:0]           bidx_q, bidx_d;
    logic [CPU_WIDTH-1:0] word_q, word_d;
    logic [7:0]           csum_q, csum_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 we_q, we_d;
    logic [IMEM_AW-1:0]   waddr_q, waddr_d;
    logic [CPU_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]           err_q, err_d;

    logic        busy;
    logic        xfer;
    logic [15:0] len_n;
    logic        len_bad;
    logic        last_word;

    assign busy = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                  (state_q == S_DATA) || (state_q == S_CSUM);
    assign xfer = busy && byte_vld;

    assign len_n     = {byte_data, cnt_q[7:0]};
    assign len_bad   = (len_n == 16'd0) || ({1'b0, len_n} > MAX_WORDS);
    assign last_word = (17'(widx_q) + 17'd1) == {1'b0, cnt_q};

    // Next-state: frame parsing, word assembly, checksum and idle timer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        csum_d  = csum_q;
        timer_d = timer_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_start) begin
                    state_d = S_LEN0;
                    widx_d  = '0;
                    bidx_d  = '0;
                    word_d  = '0;
                    csum_d  = '0;
                    timer_d = '0;
                    err_d   = E_NONE;
                end
            end
            S_LEN0: begin
                if (xfer) begin
                    cnt_d[7:0] = byte_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    cnt_d[15:8] = byte_data;
                    if (len_bad) begin
                        state_d = S_ERR;
                        err_d   = E_LEN;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d[{bidx_q, 3'b000} +: 8] = byte_data;
                    csum_d = csum_q + byte_data;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = widx_q;
                        wdata_d = word_d;
                        widx_d  = widx_q + IMEM_AW'(1);
                        if (last_word) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (byte_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        err_d   = E_CSUM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A stalled sender aborts the load; a transfer never coincides
        if (busy) begin
            if (xfer) begin
                timer_d = '0;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
                state_d = S_ERR;
                err_d   = E_TOUT;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            timer_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= E_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            timer_q <= timer_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs are forced quiet during the reset cycle itself
    assign byte_rdy   = busy && !rst;
    assign imem_we    = we_q && !rst;
    assign imem_waddr = rst ? '0 : waddr_q;
    assign imem_wdata = rst ? '0 : wdata_q;
    assign core_rst_n = (state_q == S_DONE) && !rst;
    assign load_done  = (state_q == S_DONE) && !rst;
    assign load_err   = (state_q == S_ERR) && !rst;
    assign err_code   = rst ? E_NONE : err_q;

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: randomized frames against a byte-stream reference model,
// expected memory writes go through a scoreboard checked by a monitor.
module tb_inst_loader;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        byte_vld = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_rdy;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        load_done;
    logic        load_err;
    logic [1:0]  err_code;

    inst_loader #(.CPU_WIDTH(32), .IMEM_AW(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .byte_vld(byte_vld), .byte_data(byte_data), .byte_rdy(byte_rdy),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .load_done(load_done), .load_err(load_err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] frame_w[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (imem_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_we", 32'(imem_waddr), 32'hffff_ffff);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("we_addr", 32'(imem_waddr), 32'(e.a));
                chk("we_data", imem_wdata, e.d);
            end
        end
    end

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n = 0;
        if (rnd) begin
            byte_vld = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        byte_vld  = 1'b1;
        byte_data = b;
        while (!byte_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!byte_rdy) chk("byte_rdy_wait", 32'(byte_rdy), 32'd1);
        @(negedge clk);
        byte_vld = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!load_done && !load_err && n < 3 * TO) begin
            @(negedge clk);
            n++;
        end
        if (!load_done && !load_err) chk("end_wait", 32'd0, 32'd1);
    endtask

    task automatic end_chk(input string tag, input bit done,
                           input logic [1:0] code);
        chk({tag, "_done"}, 32'(load_done), 32'(done));
        chk({tag, "_err"}, 32'(load_err), 32'(!done));
        chk({tag, "_code"}, 32'(err_code), 32'(code));
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'(done));
        chk({tag, "_pending"}, 32'(sb.size()), 32'd0);
    endtask

    // Sends frame_w as a complete frame; inj>0 pulses load_start mid-frame
    task automatic run_frame(input bit rnd, input bit bad, input int inj);
        logic [15:0] nn;
        logic [7:0]  cs;
        logic [7:0]  b;
        int          k;
        wr_t         e;
        nn = 16'(frame_w.size());
        cs = 8'd0;
        k  = 0;
        pulse_start();
        send_byte(nn[7:0], rnd);
        send_byte(nn[15:8], rnd);
        for (int i = 0; i < frame_w.size(); i++) begin
            e.a = 8'(i);
            e.d = frame_w[i];
            sb.push_back(e);
            for (int j = 0; j < 4; j++) begin
                b  = 8'(frame_w[i] >> (8 * j));
                cs = cs + b;
                send_byte(b, rnd);
                k++;
                if (k == inj) pulse_start();
            end
        end
        send_byte(bad ? cs + 8'd1 : cs, rnd);
        wait_end();
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_rdy"}, 32'(byte_rdy), 32'd0);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_waddr"}, 32'(imem_waddr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_lerr"}, 32'(load_err), 32'd0);
        chk({tag, "_code"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        int t0;
        int n;
        repeat (3) @(negedge clk);
        reset_chk("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rdy", 32'(byte_rdy), 32'd0);

        // Reference single-word program
        frame_w = {32'h0050_0093};
        run_frame(1'b0, 1'b0, 0);
        end_chk("one_word", 1'b1, 2'd0);

        // Two words with randomly gapped byte_vld
        frame_w = {$urandom, $urandom};
        run_frame(1'b1, 1'b0, 0);
        end_chk("two_word", 1'b1, 2'd0);

        // Random lengths, load_start pulsed while busy must be ignored
        for (int r = 0; r < 3; r++) begin
            frame_w.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) frame_w.push_back($urandom);
            run_frame(1'b1, 1'b0, (r == 0) ? 0 : 2 + r);
            end_chk("rand_frame", 1'b1, 2'd0);
        end

        // Length errors: zero words, and 257 words > 256
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_end();
        end_chk("len_zero", 1'b0, 2'd1);
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        wait_end();
        end_chk("len_big", 1'b0, 2'd1);

        // Checksum error still writes the word
        frame_w = {32'h0050_0093};
        run_frame(1'b0, 1'b1, 0);
        end_chk("bad_csum", 1'b0, 2'd2);

        // Timeout after 3 data bytes, measured from last accepted byte
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h93, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h50, 1'b0);
        t0 = cyc;
        n  = 0;
        while (!load_err && n < TO + 20) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 32'(cyc - t0), 32'(TO));
        end_chk("timeout", 1'b0, 2'd3);

        // Reload from ERR
        frame_w = {$urandom, $urandom, $urandom};
        run_frame(1'b1, 1'b0, 0);
        end_chk("reload", 1'b1, 2'd0);

        // Reset in the middle of DATA abandons the frame
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        sb.push_back('{a: 8'd0, d: 32'h4433_2211});
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        byte_vld = 1'b1;
        rst = 1'b1;
        #1;
        reset_chk("mid_rst");
        @(negedge clk);
        reset_chk("mid_rst_hold");
        rst = 1'b0;
        repeat (TO + 5) @(negedge clk);
        byte_vld = 1'b0;
        chk("post_rst_rdy", 32'(byte_rdy), 32'd0);
        chk("post_rst_lerr", 32'(load_err), 32'd0);
        chk("post_rst_pending", 32'(sb.size()), 32'd0);

        // Reset wins over a simultaneous load_start
        rst = 1'b1;
        load_start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load_start = 1'b0;
        @(negedge clk);
        chk("rst_prio_rdy", 32'(byte_rdy), 32'd0);
        chk("rst_prio_core", 32'(core_rst_n), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
